// File: rtl/mem_access.sv
// Purpose : MIPS32 MEM stage. Builds the data-memory address, lane-replicated store data and byte enables,
//           and extracts sign/zero-extended load data into the MEM/WB register.
// Latency : dm_* outputs are combinational from ex_*; wb_* are registered one cycle after ex_* is presented.
// Backpressure: stall holds MEM/WB and blocks the write; flush (wins over stall) loads a bubble and blocks the write.
// Ports   : clk/reset (sync, active-high); stall, flush; ex_* MEM-stage inputs from EX/MEM;
//           dm_addr/dm_wdata/dm_be/dm_we to data memory, dm_rdata combinational read word back;
//           wb_* MEM/WB register outputs; store_count counts committed stores (wraps at 2^32).
module mem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_alu,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    output logic        dm_we,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output logic        wb_adel,
    output logic        wb_ades,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic [31:0] store_count
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        adel;
        logic        ades;
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  rd;
    } memwb_t;

    memwb_t      memwb_q, memwb_d;
    logic [31:0] store_count_q, store_count_d;

    logic [1:0]  k;
    logic        is_load, is_store, misaligned;
    logic        adel, ades;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] byte_shift;
    logic [31:0] load_val;

    assign k = ex_alu[1:0];

    // Decode; opcodes 9..15 fall through as NONE.
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        unique case (ex_op)
            OP_LW:          begin is_load  = 1'b1; misaligned = (k != 2'b00); end
            OP_LH, OP_LHU:  begin is_load  = 1'b1; misaligned = k[0];         end
            OP_LB, OP_LBU:  begin is_load  = 1'b1;                             end
            OP_SW:          begin is_store = 1'b1; misaligned = (k != 2'b00); end
            OP_SH:          begin is_store = 1'b1; misaligned = k[0];         end
            OP_SB:          begin is_store = 1'b1;                             end
            default:        ;
        endcase
    end

    assign adel = ex_valid & is_load  & misaligned;
    assign ades = ex_valid & is_store & misaligned;

    // Store lanes: data is replicated so the memory only needs the enables.
    always_comb begin
        dm_wdata = ex_store_data;
        dm_be    = 4'b0000;
        unique case (ex_op)
            OP_SW: begin
                dm_wdata = ex_store_data;
                dm_be    = 4'b1111;
            end
            OP_SH: begin
                dm_wdata = {2{ex_store_data[15:0]}};
                dm_be    = k[1] ? 4'b1100 : 4'b0011;
            end
            OP_SB: begin
                dm_wdata = {4{ex_store_data[7:0]}};
                dm_be    = 4'b0001 << k;
            end
            default: ;
        endcase
    end

    assign dm_addr = ex_alu;
    // reset is in the strobe so a store caught by reset never reaches memory.
    assign dm_we   = ex_valid & is_store & ~ades & ~stall & ~flush & ~reset;

    // Load extraction, little-endian.
    assign half_sel   = k[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    assign byte_shift = dm_rdata >> {k, 3'b000};
    assign byte_sel   = byte_shift[7:0];

    always_comb begin
        load_val = dm_rdata;
        unique case (ex_op)
            OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_val = {16'h0000, half_sel};
            OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_val = {24'h000000, byte_sel};
            default: load_val = dm_rdata;
        endcase
    end

    // Next MEM/WB contents: reset > flush > stall > load.
    always_comb begin
        memwb_d = memwb_q;
        if (flush) begin
            memwb_d = '0;
        end else if (!stall) begin
            memwb_d.valid    = ex_valid;
            memwb_d.regwrite = ex_valid & ex_regwrite & ~is_store & ~adel;
            memwb_d.adel     = adel;
            memwb_d.ades     = ades;
            memwb_d.pc       = ex_pc;
            memwb_d.data     = is_load ? load_val : ex_alu;
            memwb_d.rd       = ex_rd;
        end
    end

    assign store_count_d = dm_we ? store_count_q + 32'd1 : store_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            memwb_q       <= '0;
            store_count_q <= '0;
        end else begin
            memwb_q       <= memwb_d;
            store_count_q <= store_count_d;
        end
    end

    assign wb_valid    = memwb_q.valid;
    assign wb_regwrite = memwb_q.regwrite;
    assign wb_adel     = memwb_q.adel;
    assign wb_ades     = memwb_q.ades;
    assign wb_pc       = memwb_q.pc;
    assign wb_data     = memwb_q.data;
    assign wb_rd       = memwb_q.rd;
    assign store_count = store_count_q;

endmodule

// File: tb/tb_mem_access.sv
// Purpose : self-checking bench for mem_access; expected MEM/WB state is queued at issue and checked after the edge.
// Latency : one op per cycle, inputs driven at negedge, dm_* checked mid-cycle, wb_* checked 1 time unit after posedge.
// Backpressure: stall/flush/reset are driven per op by the stimulus sequence.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset, stall, flush, ex_valid, ex_regwrite;
    logic [31:0] ex_pc, ex_alu, ex_store_data, dm_rdata;
    logic [3:0]  ex_op;
    logic [4:0]  ex_rd;
    logic [31:0] dm_addr, dm_wdata, wb_pc, wb_data, store_count;
    logic [3:0]  dm_be;
    logic        dm_we, wb_valid, wb_regwrite, wb_adel, wb_ades;
    logic [4:0]  wb_rd;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        adel;
        logic        ades;
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] count;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op), .ex_alu(ex_alu),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_we(dm_we),
        .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_adel(wb_adel), .wb_ades(wb_ades),
        .wb_pc(wb_pc), .wb_data(wb_data), .wb_rd(wb_rd), .store_count(store_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t wbx(input logic v, input logic rw, input logic adl, input logic ads,
                                 input logic [31:0] pc, input logic [31:0] data,
                                 input logic [4:0] rd, input logic [31:0] cnt);
        exp_t e;
        e.valid = v; e.regwrite = rw; e.adel = adl; e.ades = ads;
        e.pc = pc; e.data = data; e.rd = rd; e.count = cnt;
        return e;
    endfunction

    // One cycle: drive, check combinational memory side, queue expected MEM/WB, check after the edge.
    task automatic issue(input string tag, input logic v, input logic [3:0] op,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] rdat,
                         input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                         input logic st, input logic fl, input logic rs,
                         input logic [3:0] e_be, input logic [31:0] e_wd, input logic e_we,
                         input exp_t e_wb);
        exp_t got;
        @(negedge clk);
        ex_valid = v; ex_op = op; ex_alu = alu; ex_store_data = sd; dm_rdata = rdat;
        ex_pc = pc; ex_rd = rd; ex_regwrite = rw; stall = st; flush = fl; reset = rs;
        #1;
        check({tag, ".dm_addr"},  dm_addr, alu);
        check({tag, ".dm_be"},    32'(dm_be), 32'(e_be));
        check({tag, ".dm_wdata"}, dm_wdata, e_wd);
        check({tag, ".dm_we"},    32'(dm_we), 32'(e_we));
        sb_q.push_back(e_wb);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check({tag, ".wb_valid"},    32'(wb_valid),    32'(got.valid));
        check({tag, ".wb_regwrite"}, 32'(wb_regwrite), 32'(got.regwrite));
        check({tag, ".wb_adel"},     32'(wb_adel),     32'(got.adel));
        check({tag, ".wb_ades"},     32'(wb_ades),     32'(got.ades));
        check({tag, ".wb_pc"},       wb_pc,            got.pc);
        check({tag, ".wb_data"},     wb_data,          got.data);
        check({tag, ".wb_rd"},       32'(wb_rd),       32'(got.rd));
        check({tag, ".store_count"}, store_count,      got.count);
    endtask

    initial begin
        exp_t z;
        exp_t held;
        z = wbx(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'd0);
        reset = 1'b1; stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_op = 4'd0;
        ex_alu = 32'h0; ex_store_data = 32'h0; dm_rdata = 32'h0; ex_pc = 32'h0;
        ex_rd = 5'd0; ex_regwrite = 1'b0;

        // Reset with a valid SW presented: no write, everything zero.
        issue("rst0", 1, 4'd6, 32'h100, 32'h1111_2222, 32'h0, 32'h3FC, 5'd0, 0, 0, 0, 1,
              4'b1111, 32'h1111_2222, 0, z);

        // Word round trip
        issue("sw", 1, 4'd6, 32'h100, 32'h1234_5678, 32'h0, 32'h400, 5'd0, 0, 0, 0, 0,
              4'b1111, 32'h1234_5678, 1, wbx(1, 0, 0, 0, 32'h400, 32'h100, 5'd0, 32'd1));
        issue("lw", 1, 4'd1, 32'h100, 32'h0, 32'h1234_5678, 32'h404, 5'd5, 1, 0, 0, 0,
              4'b0000, 32'h0, 0, wbx(1, 1, 0, 0, 32'h404, 32'h1234_5678, 5'd5, 32'd1));

        // Byte
        issue("sb", 1, 4'd8, 32'h103, 32'h0000_00AB, 32'h0, 32'h408, 5'd0, 0, 0, 0, 0,
              4'b1000, 32'hABAB_ABAB, 1, wbx(1, 0, 0, 0, 32'h408, 32'h103, 5'd0, 32'd2));
        issue("lb", 1, 4'd4, 32'h103, 32'h0, 32'hAB00_0000, 32'h40C, 5'd6, 1, 0, 0, 0,
              4'b0000, 32'h0, 0, wbx(1, 1, 0, 0, 32'h40C, 32'hFFFF_FFAB, 5'd6, 32'd2));
        issue("lbu", 1, 4'd5, 32'h103, 32'h0, 32'hAB00_0000, 32'h410, 5'd7, 1, 0, 0, 0,
              4'b0000, 32'h0, 0, wbx(1, 1, 0, 0, 32'h410, 32'h0000_00AB, 5'd7, 32'd2));
        issue("sb0", 1, 4'd8, 32'h200, 32'hFFFF_FF5C, 32'h0, 32'h414, 5'd0, 0, 0, 0, 0,
              4'b0001, 32'h5C5C_5C5C, 1, wbx(1, 0, 0, 0, 32'h414, 32'h200, 5'd0, 32'd3));

        // Halfword
        issue("sh", 1, 4'd7, 32'h102, 32'h0000_8001, 32'h0, 32'h418, 5'd0, 0, 0, 0, 0,
              4'b1100, 32'h8001_8001, 1, wbx(1, 0, 0, 0, 32'h418, 32'h102, 5'd0, 32'd4));
        issue("lh", 1, 4'd2, 32'h102, 32'h0, 32'h8001_0000, 32'h41C, 5'd8, 1, 0, 0, 0,
              4'b0000, 32'h0, 0, wbx(1, 1, 0, 0, 32'h41C, 32'hFFFF_8001, 5'd8, 32'd4));
        issue("lhu", 1, 4'd3, 32'h102, 32'h0, 32'h8001_0000, 32'h420, 5'd9, 1, 0, 0, 0,
              4'b0000, 32'h0, 0, wbx(1, 1, 0, 0, 32'h420, 32'h0000_8001, 5'd9, 32'd4));
        issue("lh_lo", 1, 4'd2, 32'h200, 32'h0, 32'h1234_7FFF, 32'h424, 5'd10, 1, 0, 0, 0,
              4'b0000, 32'h0, 0, wbx(1, 1, 0, 0, 32'h424, 32'h0000_7FFF, 5'd10, 32'd4));
        issue("sh_lo", 1, 4'd7, 32'h200, 32'hAAAA_BEEF, 32'h0, 32'h428, 5'd0, 0, 0, 0, 0,
              4'b0011, 32'hBEEF_BEEF, 1, wbx(1, 0, 0, 0, 32'h428, 32'h200, 5'd0, 32'd5));

        // Misaligned
        issue("sw_mis", 1, 4'd6, 32'h102, 32'h0000_DEAD, 32'h0, 32'h42C, 5'd0, 0, 0, 0, 0,
              4'b1111, 32'h0000_DEAD, 0, wbx(1, 0, 0, 1, 32'h42C, 32'h102, 5'd0, 32'd5));
        issue("sh_mis", 1, 4'd7, 32'h101, 32'h0000_1234, 32'h0, 32'h430, 5'd0, 0, 0, 0, 0,
              4'b0011, 32'h1234_1234, 0, wbx(1, 0, 0, 1, 32'h430, 32'h101, 5'd0, 32'd5));
        issue("lw_mis", 1, 4'd1, 32'h101, 32'h0, 32'h55AA_55AA, 32'h434, 5'd11, 1, 0, 0, 0,
              4'b0000, 32'h0, 0, wbx(1, 0, 1, 0, 32'h434, 32'h55AA_55AA, 5'd11, 32'd5));
        issue("lhu_mis", 1, 4'd3, 32'h103, 32'h0, 32'h1234_5678, 32'h438, 5'd12, 1, 0, 0, 0,
              4'b0000, 32'h0, 0, wbx(1, 0, 1, 0, 32'h438, 32'h0000_1234, 5'd12, 32'd5));
        issue("lb_odd", 1, 4'd4, 32'h101, 32'h0, 32'h0000_8000, 32'h43C, 5'd13, 1, 0, 0, 0,
              4'b0000, 32'h0, 0, wbx(1, 1, 0, 0, 32'h43C, 32'hFFFF_FF80, 5'd13, 32'd5));
        // Bubble with misaligned LW: no flag, no regwrite
        issue("bubble", 0, 4'd1, 32'h103, 32'h0, 32'h0, 32'h440, 5'd14, 1, 0, 0, 0,
              4'b0000, 32'h0, 0, wbx(0, 0, 0, 0, 32'h440, 32'h0, 5'd14, 32'd5));
        // Undefined opcode behaves as NONE: ALU value written back
        issue("op12", 1, 4'd12, 32'hCAFE_BABE, 32'h0000_0077, 32'h0, 32'h444, 5'd15, 1, 0, 0, 0,
              4'b0000, 32'h0000_0077, 0, wbx(1, 1, 0, 0, 32'h444, 32'hCAFE_BABE, 5'd15, 32'd5));

        // Stall: SW held two cycles, MEM/WB keeps previous op, then exactly one write
        held = wbx(1, 1, 0, 0, 32'h444, 32'hCAFE_BABE, 5'd15, 32'd5);
        issue("stall1", 1, 4'd6, 32'h300, 32'h1122_3344, 32'h0, 32'h448, 5'd0, 0, 1, 0, 0,
              4'b1111, 32'h1122_3344, 0, held);
        issue("stall2", 1, 4'd6, 32'h300, 32'h1122_3344, 32'h0, 32'h448, 5'd0, 0, 1, 0, 0,
              4'b1111, 32'h1122_3344, 0, held);
        issue("unstall", 1, 4'd6, 32'h300, 32'h1122_3344, 32'h0, 32'h448, 5'd0, 0, 0, 0, 0,
              4'b1111, 32'h1122_3344, 1, wbx(1, 0, 0, 0, 32'h448, 32'h300, 5'd0, 32'd6));
        // Stall + flush: flush wins
        issue("stl_fl", 1, 4'd6, 32'h304, 32'h5566_7788, 32'h0, 32'h44C, 5'd0, 0, 1, 1, 0,
              4'b1111, 32'h5566_7788, 0, wbx(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'd6));
        issue("lw2", 1, 4'd1, 32'h304, 32'h0, 32'h0BAD_F00D, 32'h450, 5'd3, 1, 0, 0, 0,
              4'b0000, 32'h0, 0, wbx(1, 1, 0, 0, 32'h450, 32'h0BAD_F00D, 5'd3, 32'd6));
        issue("flush", 1, 4'd1, 32'h304, 32'h0, 32'h0BAD_F00D, 32'h454, 5'd3, 1, 0, 1, 0,
              4'b0000, 32'h0, 0, wbx(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'd6));

        // Reset mid-operation with a valid SW
        issue("sb_pre", 1, 4'd8, 32'h301, 32'h0000_0011, 32'h0, 32'h458, 5'd0, 0, 0, 0, 0,
              4'b0010, 32'h1111_1111, 1, wbx(1, 0, 0, 0, 32'h458, 32'h301, 5'd0, 32'd7));
        issue("rst_mid", 1, 4'd6, 32'h308, 32'h9999_0000, 32'h0, 32'h45C, 5'd0, 0, 0, 0, 1,
              4'b1111, 32'h9999_0000, 0, z);
        issue("post_rst", 1, 4'd6, 32'h308, 32'h9999_0000, 32'h0, 32'h460, 5'd0, 0, 0, 0, 0,
              4'b1111, 32'h9999_0000, 1, wbx(1, 0, 0, 0, 32'h460, 32'h308, 5'd0, 32'd1));

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the pipelined MIPS32 core, sitting between the EX/MEM pipeline register and the word-addressed data memory. It turns byte, halfword and word load/store operations into an address, lane-replicated write data and a byte-enable mask for the memory. It then extracts and sign- or zero-extends load data from the memory's combinational read word. The result is registered into the MEM/WB pipeline register with stall, flush, address-error flags and a committed-store counter.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold MEM/WB contents; suppress memory write.
- flush  in  1  kill the MEM-stage instruction; insert bubble into MEM/WB.
- ex_valid  in  1  the MEM-stage instruction is real (not a bubble).
- ex_pc  in  32  PC of the MEM-stage instruction.
- ex_op  in  4  0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; 9–15 treated as NONE.
- ex_alu  in  32  ALU result; this is the byte address for memory ops and the writeback value otherwise.
- ex_store_data  in  32  rt value for stores.
- ex_rd  in  5  destination register.
- ex_regwrite  in  1  instruction writes a register.
- dm_addr  out  32  equals ex_alu.
- dm_wdata  out  32  lane-replicated store data.
- dm_be  out  4  byte enables; bit k covers bits [8k+7:8k].
- dm_we  out  1  memory write strobe, sampled by memory at the next rising edge.
- dm_rdata  in  32  memory read word, combinational from dm_addr.
- wb_valid, wb_regwrite, wb_adel, wb_ades  out  1 each  registered MEM/WB flags.
- wb_pc  out  32,  wb_data  out  32,  wb_rd  out  5  registered MEM/WB fields.
- store_count  out  32  number of committed stores; wraps at 2^32.

## Operation
- Byte order is little-endian. Byte offset k = ex_alu[1:0].
- Alignment rules:
  - LW/SW require k == 0.
  - LH/LHU/SH require k[0] == 0.
  - Byte ops are always aligned.
- Misaligned load sets adel. Misaligned store sets ades. Both apply only when ex_valid.
- Store data and enables:
  - SW: wdata = store_data, be = 1111.
  - SH: wdata = {2{store_data[15:0]}}, be = 0011 if k[1]==0, else 1100.
  - SB: wdata = {4{store_data[7:0]}}, be = 1 << k.
  - Non-stores: be = 0000, wdata = store_data.
- dm_we = ex_valid & is_store & !ades & !stall & !flush & !reset.
- Load extraction from dm_rdata:
  - LW: the whole word.
  - LH/LHU: the half at bits [16·k[1]+15 : 16·k[1]], sign- or zero-extended.
  - LB/LBU: byte k, sign- or zero-extended.
- Next MEM/WB values:
  - valid = ex_valid.
  - data = the extracted load value for loads, ex_alu otherwise.
  - regwrite = ex_valid & ex_regwrite & !is_store & !adel.
  - adel and ades as computed above.
  - pc and rd are passed through.
- MEM/WB update priority per edge is reset > flush > stall > load:
  - flush loads a bubble (all fields 0).
  - stall holds the current contents.
- store_count increments on each edge where dm_we == 1.

## Timing
- All dm_* outputs are combinational from ex_* in the same cycle. The memory commits the write at the next rising edge.
- Load latency: ex_* presented in cycle N gives wb_data valid after the edge ending cycle N (1 cycle).
- Reset values: wb_valid, wb_regwrite, wb_adel and wb_ades are 0; wb_pc, wb_data, wb_rd and store_count are 0.
- dm_we is 0 throughout reset, including a store already in flight when reset asserts mid-operation.
- When stall and flush are both high, flush wins: a bubble is loaded, no write occurs, and the count does not change.
- An instruction held in MEM by stall issues its single write only in the first non-stalled cycle.
- store_count wraps from 0xFFFFFFFF to 0 with no flag.

## Test plan
- Word round trip: SW store_data=0x12345678, ex_alu=0x100 → dm_be=1111, dm_wdata=0x12345678, store_count=1. Then LW at 0x100 with dm_rdata=0x12345678 → wb_data=0x12345678, wb_regwrite=1.
- Byte store and loads:
  - SB store_data=0x000000AB, ex_alu=0x103 → dm_wdata=0xABABABAB, dm_be=1000.
  - LB at 0x103 with dm_rdata=0xAB000000 → wb_data=0xFFFFFFAB.
  - LBU at the same address → wb_data=0x000000AB.
- Halfword:
  - SH store_data=0x8001, ex_alu=0x102 → dm_be=1100, dm_wdata=0x80018001.
  - LH at 0x102 with dm_rdata=0x80010000 → wb_data=0xFFFF8001.
  - LHU at the same address → wb_data=0x00008001.
- Misaligned access:
  - SW at 0x102 → dm_we=0, wb_ades=1, store_count unchanged.
  - LW at 0x101 → wb_adel=1, wb_regwrite=0.
  - LB at 0x101 → no flag.
- Stall and flush with a valid SW:
  - stall=1 for 2 cycles → dm_we=0 and wb_* held.
  - Then stall=0 → exactly one write, store_count +1.
  - stall=1 with flush=1 → wb_valid=0 and no write.
- Reset mid-operation: assert reset during a valid SW → dm_we=0 that cycle, and all wb_* and store_count are 0 after the edge.
